// File: rtl/seq_det_event_logger.sv
// Timestamp logger for sequence-detector hits: free-running timestamp, FWFT FIFO,
// saturating hit counter, sticky overflow. Optional irq output with `define SEQ_LOG_IRQ_EN.
module seq_det_event_logger #(
    parameter int TS_W    = 16,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int IRQ_THR = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det_in,
    input  logic                     clr,
    input  logic                     rd_en,
    output logic [TS_W-1:0]          ts_out,
    output logic                     ts_valid,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [CNT_W-1:0]         det_cnt,
    output logic                     ovf
`ifdef SEQ_LOG_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TS_W-1:0] ts_ctr;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt_nxt;
    logic            ovf_nxt;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    assign full = (fifo_cnt == CW'(DEPTH));
    assign pop  = rd_en && ts_valid;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign push = det_in && (!full || pop);
    assign drop = det_in && full && !pop;

    always_comb begin
        cnt_nxt = fifo_cnt;
        ovf_nxt = ovf;
        if (clr) begin
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
        end else begin
            if (push && !pop) begin
                cnt_nxt = fifo_cnt + CW'(1);
            end else if (pop && !push) begin
                cnt_nxt = fifo_cnt - CW'(1);
            end
            if (drop) begin
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_ctr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ts_valid <= 1'b0;
            det_cnt  <= '0;
            ovf      <= 1'b0;
        end else begin
            fifo_cnt <= cnt_nxt;
            ts_valid <= (cnt_nxt != '0);
            ovf      <= ovf_nxt;
            if (clr) begin
                ts_ctr  <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                det_cnt <= '0;
            end else begin
                ts_ctr <= ts_ctr + TS_W'(1);
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (det_in && (det_cnt != '1)) begin
                    det_cnt <= det_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Storage is not reset; ts_out is masked by ts_valid instead.
    always_ff @(posedge clk) begin
        if (!clr && push) begin
            mem[wr_ptr] <= ts_ctr;
        end
    end

    assign ts_out = ts_valid ? mem[rd_ptr] : '0;

`ifdef SEQ_LOG_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= !clr && ((32'(cnt_nxt) >= IRQ_THR) || ovf_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_seq_det_event_logger.sv
// Directed bench for seq_det_event_logger: default instance plus a TS_W=4/CNT_W=2
// instance for wrap and saturation; irq checks are active with SEQ_LOG_IRQ_EN.
module tb_seq_det_event_logger;

    logic        clk;
    logic        rst;
    logic        det_in;
    logic        clr;
    logic        rd_en;

    logic [15:0] ts_out;
    logic        ts_valid;
    logic [2:0]  fifo_cnt;
    logic [7:0]  det_cnt;
    logic        ovf;

    logic [3:0]  s_ts_out;
    logic        s_ts_valid;
    logic [2:0]  s_fifo_cnt;
    logic [1:0]  s_det_cnt;
    logic        s_ovf;

`ifdef SEQ_LOG_IRQ_EN
    logic        irq;
    logic        s_irq;
`endif

    int checks = 0;
    int errors = 0;

    seq_det_event_logger dut (
        .clk      (clk),
        .rst      (rst),
        .det_in   (det_in),
        .clr      (clr),
        .rd_en    (rd_en),
        .ts_out   (ts_out),
        .ts_valid (ts_valid),
        .fifo_cnt (fifo_cnt),
        .det_cnt  (det_cnt),
        .ovf      (ovf)
`ifdef SEQ_LOG_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    seq_det_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2), .IRQ_THR(3)) dut_small (
        .clk      (clk),
        .rst      (rst),
        .det_in   (det_in),
        .clr      (clr),
        .rd_en    (rd_en),
        .ts_out   (s_ts_out),
        .ts_valid (s_ts_valid),
        .fifo_cnt (s_fifo_cnt),
        .det_cnt  (s_det_cnt),
        .ovf      (s_ovf)
`ifdef SEQ_LOG_IRQ_EN
        ,
        .irq      (s_irq)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; returns 1 ns after the edge.
    task automatic step(input logic d, input logic r, input logic c);
        det_in = d;
        rd_en  = r;
        clr    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges, checks outputs before any clock edge,
    // releases on a falling edge so the next rising edge sees ts_ctr=0.
    task automatic reset_dut(input string tag);
        det_in = 1'b0;
        rd_en  = 1'b0;
        clr    = 1'b0;
        rst    = 1'b0;
        #2;
        check({tag, "_rst_valid"}, 32'(ts_valid), 32'd0);
        check({tag, "_rst_ts_out"}, 32'(ts_out), 32'd0);
        check({tag, "_rst_cnt"}, 32'(fifo_cnt), 32'd0);
        check({tag, "_rst_det_cnt"}, 32'(det_cnt), 32'd0);
        check({tag, "_rst_ovf"}, 32'(ovf), 32'd0);
`ifdef SEQ_LOG_IRQ_EN
        check({tag, "_rst_irq"}, 32'(irq), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        det_in = 1'b0;
        rd_en  = 1'b0;
        clr    = 1'b0;
        @(posedge clk);
        #1;

        // First event latency, rd_en while empty ignored
        reset_dut("a");
        idle(2);                    // ts 0,1
        step(1'b0, 1'b1, 1'b0);     // ts 2, pop on empty
        check("a_empty_pop_cnt", 32'(fifo_cnt), 32'd0);
        check("a_empty_pop_valid", 32'(ts_valid), 32'd0);
        idle(2);                    // ts 3,4
        step(1'b1, 1'b0, 1'b0);     // ts 5
        check("a_valid", 32'(ts_valid), 32'd1);
        check("a_ts_out", 32'(ts_out), 32'd5);
        check("a_cnt", 32'(fifo_cnt), 32'd1);
        check("a_det_cnt", 32'(det_cnt), 32'd1);
        check("a_ovf", 32'(ovf), 32'd0);

        // Overflow with five events at 2,3,4,9,12, then drain
        reset_dut("b");
        idle(2);                    // ts 0,1
        step(1'b1, 1'b0, 1'b0);     // ts 2
        step(1'b1, 1'b0, 1'b0);     // ts 3
`ifdef SEQ_LOG_IRQ_EN
        check("b_irq_below_thr", 32'(irq), 32'd0);
`endif
        step(1'b1, 1'b0, 1'b0);     // ts 4
        check("b_cnt3", 32'(fifo_cnt), 32'd3);
`ifdef SEQ_LOG_IRQ_EN
        check("b_irq_at_thr", 32'(irq), 32'd1);
`endif
        idle(4);                    // ts 5..8
        step(1'b1, 1'b0, 1'b0);     // ts 9
        idle(2);                    // ts 10,11
        step(1'b1, 1'b0, 1'b0);     // ts 12, dropped
        check("b_cnt_full", 32'(fifo_cnt), 32'd4);
        check("b_ovf", 32'(ovf), 32'd1);
        check("b_det_cnt", 32'(det_cnt), 32'd5);
        check("b_head0", 32'(ts_out), 32'd2);
        step(1'b0, 1'b1, 1'b0);
        check("b_head1", 32'(ts_out), 32'd3);
        step(1'b0, 1'b1, 1'b0);
        check("b_head2", 32'(ts_out), 32'd4);
        step(1'b0, 1'b1, 1'b0);
        check("b_head3", 32'(ts_out), 32'd9);
`ifdef SEQ_LOG_IRQ_EN
        check("b_irq_ovf_sticky", 32'(irq), 32'd1);
`endif
        step(1'b0, 1'b1, 1'b0);
        check("b_drained_valid", 32'(ts_valid), 32'd0);
        check("b_drained_cnt", 32'(fifo_cnt), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        check("b_empty_pop_cnt", 32'(fifo_cnt), 32'd0);
        check("b_ovf_kept", 32'(ovf), 32'd1);

        // Push and pop on a full FIFO, then on an empty FIFO
        reset_dut("c");
        step(1'b1, 1'b0, 1'b0);     // ts 0
        step(1'b1, 1'b0, 1'b0);     // ts 1
        step(1'b1, 1'b0, 1'b0);     // ts 2
        step(1'b1, 1'b0, 1'b0);     // ts 3
        idle(16);                   // ts 4..19
        step(1'b1, 1'b1, 1'b0);     // ts 20
        check("c_cnt", 32'(fifo_cnt), 32'd4);
        check("c_ovf", 32'(ovf), 32'd0);
        check("c_head", 32'(ts_out), 32'd1);
        step(1'b0, 1'b1, 1'b0);     // ts 21
        check("c_pop1", 32'(ts_out), 32'd2);
        step(1'b0, 1'b1, 1'b0);     // ts 22
        check("c_pop2", 32'(ts_out), 32'd3);
`ifdef SEQ_LOG_IRQ_EN
        check("c_irq_below_thr", 32'(irq), 32'd0);
`endif
        step(1'b0, 1'b1, 1'b0);     // ts 23
        check("c_tail", 32'(ts_out), 32'd20);
        step(1'b0, 1'b1, 1'b0);     // ts 24
        check("c_empty", 32'(ts_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);     // ts 25, empty push+pop
        check("c_emp_pp_cnt", 32'(fifo_cnt), 32'd1);
        check("c_emp_pp_ts", 32'(ts_out), 32'd25);

        // Synchronous clear beats det_in, then async reset mid-stream
        reset_dut("d");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);   // ts 0..4
        check("d_ovf_pre", 32'(ovf), 32'd1);
        check("d_det_cnt_pre", 32'(det_cnt), 32'd5);
        step(1'b1, 1'b1, 1'b1);     // ts 5, clear wins
        check("d_clr_cnt", 32'(fifo_cnt), 32'd0);
        check("d_clr_valid", 32'(ts_valid), 32'd0);
        check("d_clr_det_cnt", 32'(det_cnt), 32'd0);
        check("d_clr_ovf", 32'(ovf), 32'd0);
`ifdef SEQ_LOG_IRQ_EN
        check("d_clr_irq", 32'(irq), 32'd0);
`endif
        idle(2);                    // ts 0,1
        step(1'b1, 1'b0, 1'b0);     // ts 2
        check("d_post_clr_ts", 32'(ts_out), 32'd2);
        check("d_post_clr_det", 32'(det_cnt), 32'd1);
        step(1'b1, 1'b0, 1'b0);     // ts 3
        check("d_pre_rst_cnt", 32'(fifo_cnt), 32'd2);
        reset_dut("d_mid");
        step(1'b1, 1'b0, 1'b0);     // ts 0
        check("d_post_rst_valid", 32'(ts_valid), 32'd1);
        check("d_post_rst_ts", 32'(ts_out), 32'd0);
        step(1'b1, 1'b0, 1'b0);     // ts 1
        check("d_post_rst_cnt", 32'(fifo_cnt), 32'd2);
        step(1'b0, 1'b1, 1'b0);
        check("d_post_rst_pop", 32'(ts_out), 32'd1);

        // Narrow instance: timestamp wrap and counter saturation
        reset_dut("e");
        check("e_rst_valid", 32'(s_ts_valid), 32'd0);
        check("e_rst_det_cnt", 32'(s_det_cnt), 32'd0);
        idle(15);                   // ts 0..14
        step(1'b1, 1'b0, 1'b0);     // ts 15
        check("e_ts15", 32'(s_ts_out), 32'd15);
        step(1'b1, 1'b0, 1'b0);     // ts 0 after wrap
        step(1'b1, 1'b0, 1'b0);     // ts 1
        step(1'b1, 1'b0, 1'b0);     // ts 2
        check("e_det_cnt_sat", 32'(s_det_cnt), 32'd3);
        step(1'b1, 1'b0, 1'b0);     // ts 3, dropped
        check("e_det_cnt_5", 32'(s_det_cnt), 32'd3);
        check("e_ovf", 32'(s_ovf), 32'd1);
        check("e_cnt", 32'(s_fifo_cnt), 32'd4);
        check("e_head", 32'(s_ts_out), 32'd15);
        step(1'b0, 1'b1, 1'b0);
        check("e_pop_wrap", 32'(s_ts_out), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        check("e_pop_next", 32'(s_ts_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
